// File: rtl/axi_burst_reader.sv
// axi_burst_reader: issues one AXI4 INCR read burst per command and forwards
// the returned beats through a single registered output stage with
// valid/ready flow control. A sticky err flag reports bad responses.
// Build option: define AXI_BURST_READER_CHECK_EN to also flag beats whose
// rid differs from ARID or whose rlast disagrees with the expected final beat.
module axi_burst_reader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 16,
  parameter int          ID_WIDTH   = 8,
  parameter int unsigned ARID       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state;
  logic                  arvalid_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  last_p1;
  logic                  vld_p1;
  logic                  cmd_hs;
  logic                  beat_hs;
  logic                  beat_bad;
  logic                  final_beat;

  // The beat counter holds beats-remaining-minus-one, so zero marks the last beat.
  assign final_beat = (cnt_q == 8'd0);

  assign cmd_ready = (state == IDLE) && !rst;
  assign cmd_hs    = cmd_valid && cmd_ready;

  // Accept a new beat only when the output register is empty or draining now.
  assign m_axi_rready = (state == DATA) && !rst && (!vld_p1 || out_ready);
  assign beat_hs      = m_axi_rvalid && m_axi_rready;

`ifdef AXI_BURST_READER_CHECK_EN
  assign beat_bad = (m_axi_rresp != 2'b00) ||
                    (m_axi_rid != ID_WIDTH'(ARID)) ||
                    (m_axi_rlast != final_beat);
`else
  assign beat_bad = (m_axi_rresp != 2'b00);
  // rid and rlast carry no meaning for this build.
  logic unused_ok;
  assign unused_ok = ^{m_axi_rid, m_axi_rlast};
`endif

  assign m_axi_arid    = ID_WIDTH'(ARID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;

  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_valid = vld_p1;
  assign err       = err_q;
  assign busy      = (state != IDLE) || vld_p1;

  // Control FSM: command accept, address handshake, beat collection, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            state     <= ADDR;
            arvalid_q <= 1'b1;
            err_q     <= 1'b0;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            state     <= DATA;
            arvalid_q <= 1'b0;
          end
        end
        DATA: begin
          if (beat_hs) begin
            if (beat_bad) begin
              err_q <= 1'b1;
            end
            if (final_beat) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Command fields and beat counter; handshakes are already blocked during reset.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_q <= cmd_addr & ALIGN_MASK;
      len_q  <= cmd_len;
      cnt_q  <= cmd_len;
    end else if (beat_hs) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // ---- stage p1: output beat register (valid/last are control, data is not reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (beat_hs) begin
      vld_p1  <= 1'b1;
      last_p1 <= final_beat;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Beat payload capture for stage p1.
  always_ff @(posedge clk) begin
    if (beat_hs) begin
      data_p1 <= m_axi_rdata;
    end
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: bench-side responder plus a transaction-level
// model (expected beat queue, outstanding/pending counts, sticky error).
module tb_axi_burst_reader;

  localparam int          DW     = 32;
  localparam int          AW     = 16;
  localparam int          IW     = 8;
  localparam int unsigned ARID_P = 33;
`ifdef AXI_BURST_READER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          err;
  logic          busy;

  axi_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .ARID(ARID_P)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // transaction-level model state
  bit            outstanding, ar_pend, in_data, model_err;
  int            ar_wait, ar_delay, r_idx, beats_acc, pend, exp_len;
  logic [AW-1:0] exp_addr;
  beat_t         exp_q[$];
  logic [DW-1:0] got_q[$];
  int            last_cnt, data_cyc, cyc;
  int            bad_resp_idx, bad_rid_idx, early_last_idx, or_mode, rv_mode;

  // handshakes sampled mid-cycle, applied to the model after the edge
  bit            s_c, s_ar, s_r, s_o, s_rst;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_word(input logic [AW-1:0] a, input int i);
    return {a, 8'h5A, 8'(i)};
  endfunction

  function automatic bit beat_is_bad(input int i);
    bit b;
    b = (i == bad_resp_idx);
    if (CHK_EN) b = b || (i == bad_rid_idx) || (i == early_last_idx);
    return b;
  endfunction

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_ready", cmd_ready, !rst && !outstanding);
      chk("rready", m_axi_rready, !rst && in_data && (!out_valid || out_ready));
      chk("arvalid", m_axi_arvalid, ar_pend);
      if (ar_pend) begin
        chk("araddr", m_axi_araddr, exp_addr);
        chk("arlen", m_axi_arlen, 8'(exp_len));
        chk("arsize", m_axi_arsize, $clog2(DW / 8));
        chk("arburst", m_axi_arburst, 2'b01);
        chk("arid", m_axi_arid, ARID_P);
      end
      chk("out_valid", out_valid, pend != 0);
      chk("busy", busy, outstanding || pend != 0);
      chk("err", err, model_err);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_beat: got unexpected beat 0x%0h, expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_last", out_last, exp_q[0].l);
          if (out_ready) begin
            got_q.push_back(out_data);
            if (out_last) last_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // One clock: sample handshakes, pass the edge, update model, drive responder.
  task automatic cycle();
    @(negedge clk);
    s_c    = cmd_valid && cmd_ready;
    s_ar   = m_axi_arvalid && m_axi_arready;
    s_r    = m_axi_rvalid && m_axi_rready;
    s_o    = out_valid && out_ready;
    s_rst  = rst;
    s_addr = cmd_addr;
    s_len  = cmd_len;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      outstanding = 0; ar_pend = 0; in_data = 0; model_err = 0;
      pend = 0; r_idx = 0; beats_acc = 0;
      exp_q.delete();
    end else begin
      if (s_c) begin
        outstanding = 1; ar_pend = 1; ar_wait = 0; in_data = 0; model_err = 0;
        r_idx = 0; beats_acc = 0;
        exp_addr = AW'((int'(s_addr) / (DW / 8)) * (DW / 8));
        exp_len = int'(s_len);
        for (int i = 0; i <= exp_len; i++) exp_q.push_back({beat_word(exp_addr, i), (i == exp_len)});
      end
      if (in_data) data_cyc++;
      if (s_r) begin
        if (beat_is_bad(r_idx)) model_err = 1;
        r_idx++;
        beats_acc++;
        if (r_idx > exp_len) begin
          in_data = 0;
          outstanding = 0;
        end
      end
      if (s_ar) begin
        ar_pend = 0;
        in_data = 1;
      end else if (ar_pend && !s_c) begin
        ar_wait++;
      end
      pend = pend + int'(s_r) - int'(s_o);
    end
    m_axi_arready = ar_pend && (ar_wait >= ar_delay);
    m_axi_rvalid  = in_data && ((rv_mode == 0) || (cyc % 2 == 0));
    m_axi_rdata   = beat_word(exp_addr, r_idx);
    m_axi_rresp   = (r_idx == bad_resp_idx) ? 2'b10 : 2'b00;
    m_axi_rid     = (r_idx == bad_rid_idx) ? IW'(ARID_P + 1) : IW'(ARID_P);
    m_axi_rlast   = (r_idx == exp_len) || (r_idx == early_last_idx);
    case (or_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = (cyc % 3 != 2);
      default: out_ready = 1'b1;
    endcase
    #1;
  endtask

  task automatic issue_cmd(input logic [AW-1:0] a, input logic [7:0] l);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    do begin
      cycle();
      n++;
    end while (!s_c && n < 50);
    cmd_valid = 1'b0;
    n_cmp++;
    if (!s_c) begin
      n_fail++;
      $display("FAIL cmd_accept_timeout: got no accept after %0d cycles, expected accept", n);
    end
  endtask

  task automatic run_idle(input string name);
    int n;
    n = 0;
    while ((outstanding || pend != 0) && n < 300) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (outstanding || pend != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got burst active after %0d cycles, expected idle", name, n);
    end
    cycle();
    chk({name, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (beats_acc < k && n < 100) begin
      cycle();
      n++;
    end
    chk("wait_beats", beats_acc, k);
  endtask

  task automatic new_test();
    got_q.delete();
    last_cnt = 0;
    data_cyc = 0;
    bad_resp_idx = -1; bad_rid_idx = -1; early_last_idx = -1;
    or_mode = 0; rv_mode = 0; ar_delay = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rid = '0; m_axi_rlast = 1'b0; out_ready = 1'b1;
    outstanding = 0; ar_pend = 0; in_data = 0; model_err = 0;
    ar_wait = 0; r_idx = 0; beats_acc = 0; pend = 0; exp_len = 0; exp_addr = '0; cyc = 0;
    new_test();

    // reset state
    cycle();
    chk_on = 1'b1;
    cycle();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cycle();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // basic 4-beat burst, arready immediate
    new_test();
    issue_cmd(16'h0104, 8'd3);
    chk("t1_arvalid", m_axi_arvalid, 1'b1);
    chk("t1_araddr", m_axi_araddr, 16'h0104);
    chk("t1_arlen", m_axi_arlen, 8'd3);
    chk("t1_arsize", m_axi_arsize, 3'd2);
    chk("t1_arburst", m_axi_arburst, 2'b01);
    run_idle("t1");
    chk("t1_beats", got_q.size(), 4);
    chk("t1_lasts", last_cnt, 1);
    chk("t1_data_cycles", data_cyc, 4);
    chk("t1_word0", got_q[0], 32'h01045A00);
    chk("t1_word3", got_q[3], 32'h01045A03);
    chk("t1_err", err, 1'b0);

    // unaligned single-beat command
    new_test();
    issue_cmd(16'h0007, 8'd0);
    chk("t2_araddr", m_axi_araddr, 16'h0004);
    begin
      int n;
      n = 0;
      do begin
        cycle();
        n++;
      end while (!s_r && n < 20);
    end
    chk("t2_cmd_ready_after_beat", cmd_ready, 1'b1);
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_last", out_last, 1'b1);
    chk("t2_out_data", out_data, 32'h00045A00);
    run_idle("t2");

    // downstream backpressure toggling every cycle
    new_test();
    or_mode = 1;
    issue_cmd(16'h0200, 8'd7);
    run_idle("t3");
    chk("t3_beats", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t3_word", got_q[i], 32'h02005A00 + i);
    chk("t3_lasts", last_cnt, 1);

    // error response on beat 2
    new_test();
    bad_resp_idx = 1;
    issue_cmd(16'h0300, 8'd3);
    wait_beats(2);
    chk("t4_err_after_beat2", err, 1'b1);
    run_idle("t4");
    chk("t4_err_sticky", err, 1'b1);

    // wrong rid on beat 1
    new_test();
    bad_rid_idx = 0;
    issue_cmd(16'h0400, 8'd3);
    chk("t5_err_cleared_on_accept", err, 1'b0);
    run_idle("t5");
    chk("t5_err", err, CHK_EN);
    chk("t5_lasts", last_cnt, 1);
    chk("t5_beats", got_q.size(), 4);

    // early rlast on beat 1
    new_test();
    early_last_idx = 0;
    issue_cmd(16'h0440, 8'd3);
    run_idle("t6");
    chk("t6_err", err, CHK_EN);
    chk("t6_lasts", last_cnt, 1);
    chk("t6_word3", got_q[3], 32'h04405A03);

    // slow arready, gappy rvalid, irregular out_ready
    new_test();
    ar_delay = 3; rv_mode = 1; or_mode = 2;
    issue_cmd(16'h0522, 8'd5);
    run_idle("t7");
    chk("t7_beats", got_q.size(), 6);
    chk("t7_word5", got_q[5], 32'h05205A05);

    // reset in the middle of a data phase
    new_test();
    bad_resp_idx = 0;
    issue_cmd(16'h0600, 8'd7);
    wait_beats(2);
    chk("t8_err_before_rst", err, 1'b1);
    rst = 1'b1;
    cycle();
    chk("t8_rst_cmd_ready", cmd_ready, 1'b0);
    chk("t8_rst_rready", m_axi_rready, 1'b0);
    chk("t8_rst_out_valid", out_valid, 1'b0);
    chk("t8_rst_err", err, 1'b0);
    chk("t8_rst_busy", busy, 1'b0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("t8_release_cmd_ready", cmd_ready, 1'b1);
    new_test();
    issue_cmd(16'h0700, 8'd1);
    run_idle("t8b");
    chk("t8b_beats", got_q.size(), 2);
    chk("t8b_word1", got_q[1], 32'h07005A01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_reader.md
AXI_BURST_READER -- requirements
Module: axi_burst_reader

Interface
REQ-001 DATA_WIDTH, default 32, AXI read data width in bits; power-of-two multiple of 8.
REQ-002 ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 ID_WIDTH, default 8, width of arid/rid.
REQ-004 ARID, default 0, constant ID driven on every read burst.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  read command offered.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_addr  in  ADDR_WIDTH  start byte address.
REQ-010 cmd_len  in  8  beats minus one (0..255).
REQ-011 m_axi_arid  out  ID_WIDTH  equals ARID.
REQ-012 m_axi_araddr  out  ADDR_WIDTH  burst start address, word-aligned.
REQ-013 m_axi_arlen  out  8  latched cmd_len.
REQ-014 m_axi_arsize  out  3  log2(DATA_WIDTH/8), constant.
REQ-015 m_axi_arburst  out  2  constant 2'b01 (INCR).
REQ-016 m_axi_arvalid  out  1  address valid.
REQ-017 m_axi_arready  in  1  address accepted.
REQ-018 m_axi_rid  in  ID_WIDTH  read ID.
REQ-019 m_axi_rdata  in  DATA_WIDTH  read beat data.
REQ-020 m_axi_rresp  in  2  beat response.
REQ-021 m_axi_rlast  in  1  final beat from responder.
REQ-022 m_axi_rvalid  in  1  beat valid.
REQ-023 m_axi_rready  out  1  beat accepted.
REQ-024 out_data  out  DATA_WIDTH  registered beat data.
REQ-025 out_last  out  1  final expected beat of command.
REQ-026 out_valid  out  1  output beat valid.
REQ-027 out_ready  in  1  downstream accepts output beat.
REQ-028 err  out  1  sticky error flag.
REQ-029 busy  out  1  command in progress or output beat pending.

Function
REQ-030 States IDLE, ADDR, DATA; cmd_ready SHALL equal (state==IDLE && !rst).
REQ-031 Command accept at cycle T: latch cmd_addr with low log2(DATA_WIDTH/8) bits zeroed, latch cmd_len into beat counter, clear err; m_axi_arvalid high at T+1 (ADDR).
REQ-032 ADDR: arvalid and all ar fields held stable until arvalid&&arready; then DATA next cycle, arvalid low.
REQ-033 DATA: m_axi_rready SHALL equal (!out_valid || out_ready); rready low in IDLE and ADDR.
REQ-034 Beat accepted (rvalid&&rready) at cycle N: out_data=rdata, out_last=(counter==0), out_valid=1 at N+1; counter decrements.
REQ-035 out_valid SHALL clear after out_ready with no new beat that cycle; simultaneous accept and drain keeps out_valid high with new data, no bubble.
REQ-036 Beat with counter==0 accepted: return to IDLE next cycle; cmd_ready high while final out beat may still be pending.
REQ-037 rresp != 2'b00 on any accepted beat SHALL set err; err holds until next command accept.
REQ-038 out_last SHALL follow the internal counter only, never m_axi_rlast.
REQ-039 busy = (state != IDLE) || out_valid.
REQ-040 Throughput: one beat per cycle when rvalid and out_ready held high.

Reset
REQ-041 While rst high: state IDLE, cmd_ready 0, arvalid 0, rready 0, out_valid 0, out_last 0, err 0, busy 0; out_data value unspecified.
REQ-042 Reset mid-burst SHALL abandon the burst with no further rready; draining the responder is the system's responsibility.

Configuration
REQ-043 AXI_BURST_READER_CHECK_EN defined: err also set on accepted beat where rid != ARID or rlast != (counter==0).
REQ-044 AXI_BURST_READER_CHECK_EN undefined: rid and rlast ignored; err from rresp only.

Verification
REQ-045 Command addr 0x0104, len 3, arready same cycle, rvalid continuous, out_ready=1 -> araddr 0x0104, arlen 3, arsize 2, arburst 01, four out beats, out_last on fourth only, err 0.
REQ-046 cmd_addr 0x0007, len 0 -> araddr 0x0004, single beat with out_last=1, cmd_ready high one cycle after that beat's acceptance.
REQ-047 out_ready toggled 1/0 every cycle during len 7 burst -> rready drops while out_valid&&!out_ready, all 8 data words delivered in order, none lost or duplicated.
REQ-048 Beat 2 of len 3 has rresp=2'b10 -> err high from next cycle, stays high through burst, clears on next command accept.
REQ-049 With CHECK_EN, rid=ARID+1 or early rlast on beat 1 of len 3 -> err set; without CHECK_EN -> err stays 0, out_last still on beat 4.
REQ-050 rst asserted during DATA after 2 of 8 beats -> next cycle cmd_ready 0, rready 0, out_valid 0, err 0; after release cmd_ready 1.
